// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-port register-file write arbiter with buffered port B and stale-write kill
module regfile_write_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    input  logic [2:0]  a_reg,
    input  logic [15:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [2:0]  b_reg,
    input  logic [15:0] b_data,
    output logic        b_ready,
    output logic        rf_reg_write,
    output logic [2:0]  rf_write_reg,
    output logic [15:0] rf_write_data,
    output logic [7:0]  busy_mask
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [AW:0]             wr_ptr;
    logic [AW:0]             rd_ptr;
    logic [AW-1:0]           wr_idx;
    logic [AW-1:0]           rd_idx;
    logic [2:0]              fifo_reg  [FIFO_DEPTH];
    logic [15:0]             fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_vld;
    logic [CW-1:0]           starve_cnt;

    logic full;
    logic empty;
    logic force_b;
    logic a_win;
    logic pop;
    logic push;
    logic push_store;

    assign wr_idx  = wr_ptr[AW-1:0];
    assign rd_idx  = rd_ptr[AW-1:0];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign force_b = (starve_cnt == CW'(STARVE_LIMIT));

    // A is locked out for one cycle once B has been starved long enough.
    assign a_ready    = !force_b;
    assign b_ready    = !full;
    assign a_win      = a_valid && a_ready && (a_reg != 3'd0);
    assign pop        = !empty && !a_win;
    assign push       = b_valid && b_ready;
    assign push_store = push && (b_reg != 3'd0);

    // Pointers advance on every push/pop; r0 pushes handshake but take no slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_store) wr_ptr <= wr_ptr + 1'b1;
            if (pop)        rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry payload storage; only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (push_store) begin
            fifo_reg[wr_idx]  <= b_reg;
            fifo_data[wr_idx] <= b_data;
        end
    end

    // Valid bits: cleared on pop or when A overwrites the same register; a
    // same-cycle push is newer than the A write, so its set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_vld <= '0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if ((pop && rd_idx == AW'(i)) || (a_win && fifo_reg[i] == a_reg))
                    fifo_vld[i] <= 1'b0;
            end
            if (push_store) fifo_vld[wr_idx] <= 1'b1;
        end
    end

    // Count cycles where A holds the port while B has work waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (empty || pop) begin
            starve_cnt <= '0;
        end else if (!force_b) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    // Registered register-file write port; a killed head issues as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_reg_write  <= 1'b0;
            rf_write_reg  <= 3'd0;
            rf_write_data <= 16'd0;
        end else if (a_win) begin
            rf_reg_write  <= 1'b1;
            rf_write_reg  <= a_reg;
            rf_write_data <= a_data;
        end else if (pop) begin
            rf_reg_write  <= fifo_vld[rd_idx];
            rf_write_reg  <= fifo_reg[rd_idx];
            rf_write_data <= fifo_data[rd_idx];
        end else begin
            rf_reg_write  <= 1'b0;
        end
    end

    // Registers with a pending buffered write.
    always_comb begin
        busy_mask = 8'd0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_vld[i]) busy_mask[fifo_reg[i]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed vector bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid;
    logic [2:0]  a_reg;
    logic [15:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [2:0]  b_reg;
    logic [15:0] b_data;
    logic        b_ready;
    logic        rf_reg_write;
    logic [2:0]  rf_write_reg;
    logic [15:0] rf_write_data;
    logic [7:0]  busy_mask;

    int errors = 0;
    int checks = 0;
    logic [15:0] rf_model [8];

    regfile_write_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .rf_reg_write(rf_reg_write), .rf_write_reg(rf_write_reg),
        .rf_write_data(rf_write_data), .busy_mask(busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_reg_write) rf_model[rf_write_reg] <= rf_write_data;
    end

    typedef struct {
        logic        av;
        logic [2:0]  ar;
        logic [15:0] ad;
        logic        bv;
        logic [2:0]  br;
        logic [15:0] bd;
        logic        ear;
        logic        ebr;
        logic        ewe;
        logic [2:0]  ereg;
        logic [15:0] edata;
        logic [7:0]  ebusy;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic av, input logic [2:0] ar, input logic [15:0] ad,
                                input logic bv, input logic [2:0] br, input logic [15:0] bd,
                                input logic ear, input logic ebr, input logic ewe,
                                input logic [2:0] ereg, input logic [15:0] edata,
                                input logic [7:0] ebusy);
        vec_t v;
        v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
        v.ear = ear; v.ebr = ebr; v.ewe = ewe; v.ereg = ereg; v.edata = edata; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [2:0] ar, input logic [15:0] ad,
                         input logic bv, input logic [2:0] br, input logic [15:0] bd);
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
    endtask

    task automatic check_rf(input string name, input logic ewe, input logic [2:0] ereg,
                            input logic [15:0] edata);
        check({name, ".we"}, {15'd0, rf_reg_write}, {15'd0, ewe});
        if (ewe) begin
            check({name, ".reg"}, {13'd0, rf_write_reg}, {13'd0, ereg});
            check({name, ".data"}, rf_write_data, edata);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf_model[i] = 16'd0;
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
        #12;
        check("reset.a_ready", {15'd0, a_ready}, 16'd1);
        check("reset.b_ready", {15'd0, b_ready}, 16'd1);
        check("reset.busy", {8'd0, busy_mask}, 16'd0);
        check("reset.we", {15'd0, rf_reg_write}, 16'd0);
        check("reset.reg", {13'd0, rf_write_reg}, 16'd0);
        check("reset.data", rf_write_data, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //              av ar    ad       bv br    bd       ear ebr ewe ereg  edata    ebusy
        vecs[0]  = mk(1, 3'd3, 16'h00AA, 0, 3'd0, 16'h0000, 1, 1, 1, 3'd3, 16'h00AA, 8'h00);
        vecs[1]  = mk(1, 3'd1, 16'h0101, 1, 3'd5, 16'h1111, 1, 1, 1, 3'd1, 16'h0101, 8'h20);
        vecs[2]  = mk(1, 3'd2, 16'h0202, 1, 3'd6, 16'h2222, 1, 1, 1, 3'd2, 16'h0202, 8'h60);
        vecs[3]  = mk(0, 3'd0, 16'h0000, 1, 3'd7, 16'h3333, 1, 0, 1, 3'd5, 16'h1111, 8'h40);
        vecs[4]  = mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 1, 3'd6, 16'h2222, 8'h00);
        vecs[5]  = mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd0, 16'h0000, 8'h00);
        vecs[6]  = mk(1, 3'd1, 16'h0111, 1, 3'd4, 16'h0BBB, 1, 1, 1, 3'd1, 16'h0111, 8'h10);
        vecs[7]  = mk(1, 3'd4, 16'h0AAA, 0, 3'd0, 16'h0000, 1, 1, 1, 3'd4, 16'h0AAA, 8'h00);
        vecs[8]  = mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd0, 16'h0000, 8'h00);
        vecs[9]  = mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd0, 16'h0000, 8'h00);
        vecs[10] = mk(1, 3'd3, 16'h0333, 1, 3'd3, 16'h0B33, 1, 1, 1, 3'd3, 16'h0333, 8'h08);
        vecs[11] = mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 1, 3'd3, 16'h0B33, 8'h00);
        vecs[12] = mk(1, 3'd1, 16'h0001, 1, 3'd2, 16'h0002, 1, 1, 1, 3'd1, 16'h0001, 8'h04);
        vecs[13] = mk(0, 3'd0, 16'h0000, 1, 3'd5, 16'h0005, 1, 1, 1, 3'd2, 16'h0002, 8'h20);
        vecs[14] = mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 1, 3'd5, 16'h0005, 8'h00);
        vecs[15] = mk(1, 3'd0, 16'hFFFF, 1, 3'd0, 16'hFFFF, 1, 1, 0, 3'd0, 16'h0000, 8'h00);
        vecs[16] = mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 0, 3'd0, 16'h0000, 8'h00);
        vecs[17] = mk(1, 3'd1, 16'h0010, 1, 3'd6, 16'h0060, 1, 1, 1, 3'd1, 16'h0010, 8'h40);
        vecs[18] = mk(1, 3'd0, 16'h1234, 0, 3'd0, 16'h0000, 1, 1, 1, 3'd6, 16'h0060, 8'h00);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].bv, vecs[i].br, vecs[i].bd);
            #1;
            check($sformatf("v%0d.a_ready", i), {15'd0, a_ready}, {15'd0, vecs[i].ear});
            check($sformatf("v%0d.b_ready", i), {15'd0, b_ready}, {15'd0, vecs[i].ebr});
            @(posedge clk); #1;
            check_rf($sformatf("v%0d", i), vecs[i].ewe, vecs[i].ereg, vecs[i].edata);
            check($sformatf("v%0d.busy", i), {8'd0, busy_mask}, {8'd0, vecs[i].ebusy});
        end
        check("kill.r4_final", rf_model[4], 16'h0AAA);

        // Starvation: B entry waits while A streams; fifth cycle is forced to B.
        drive(1'b1, 3'd1, 16'h0100, 1'b1, 3'd2, 16'h0022);
        @(posedge clk); #1;
        check("starve.push_busy", {8'd0, busy_mask}, 16'h0004);
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 3'd1, 16'h0100 + 16'(k), 1'b0, 3'd0, 16'd0);
            #1;
            check($sformatf("starve.c%0d.a_ready", k), {15'd0, a_ready}, (k == 5) ? 16'd0 : 16'd1);
            @(posedge clk); #1;
            if (k == 5) check_rf("starve.c5", 1'b1, 3'd2, 16'h0022);
            else        check_rf($sformatf("starve.c%0d", k), 1'b1, 3'd1, 16'h0100 + 16'(k));
        end
        #1;
        check("starve.resume.a_ready", {15'd0, a_ready}, 16'd1);
        @(posedge clk); #1;
        check_rf("starve.resume", 1'b1, 3'd1, 16'h0105);

        // Reset mid-drain: fill FIFO, let one entry drain, then assert reset.
        drive(1'b1, 3'd1, 16'h0011, 1'b1, 3'd5, 16'h0555);
        @(posedge clk); #1;
        drive(1'b1, 3'd1, 16'h0012, 1'b1, 3'd6, 16'h0666);
        @(posedge clk); #1;
        check("rst.full_b_ready", {15'd0, b_ready}, 16'd0);
        drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
        @(posedge clk); #1;
        check_rf("rst.drain", 1'b1, 3'd5, 16'h0555);
        rst_n = 1'b0;
        #1;
        check("rst.we", {15'd0, rf_reg_write}, 16'd0);
        check("rst.b_ready", {15'd0, b_ready}, 16'd1);
        check("rst.a_ready", {15'd0, a_ready}, 16'd1);
        check("rst.busy", {8'd0, busy_mask}, 16'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("rst.after%0d.we", k), {15'd0, rf_reg_write}, 16'd0);
            check($sformatf("rst.after%0d.busy", k), {8'd0, busy_mask}, 16'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
